// File: rtl/rv_pkg.sv
// Shared widths and writeback source encoding for the register-file write path.
package rv_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-source writeback arbiter: round-robin on contention, or fixed load-wins priority.
module wb_rr_arbiter
  import rv_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_grant,
  output logic mem_grant
);

  src_t last_grant_q, last_grant_d;

  always_comb begin
    alu_grant    = 1'b0;
    mem_grant    = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_valid && mem_valid) begin
      // On contention the source that did not win last time goes first.
      if (RR_EN && (last_grant_q == SRC_MEM)) alu_grant = 1'b1;
      else                                    mem_grant = 1'b1;
    end else begin
      alu_grant = alu_valid;
      mem_grant = mem_valid;
    end
    if (alu_grant)      last_grant_d = SRC_ALU;
    else if (mem_grant) last_grant_d = SRC_MEM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= SRC_ALU;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port controller: arbitrates ALU/load writebacks, registers the
// write, and keeps a per-register busy scoreboard for decode hazard stalls.
module regfile_wb_scoreboard
  import rv_pkg::*;
#(
  parameter int DATA_W = rv_pkg::DATA_W,
  parameter int ADDR_W = rv_pkg::ADDR_W,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic                   issue_ready,
  input  logic [ADDR_W-1:0]      chk_rs1,
  input  logic [ADDR_W-1:0]      chk_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  // Handshake: a writeback transfers when valid && ready in the same cycle; a source
  // holds rd/data stable while valid && !ready; at most one source is granted per cycle.
  logic alu_grant, mem_grant, xfer;
  logic [ADDR_W-1:0]    xfer_rd;
  logic [DATA_W-1:0]    xfer_data;
  logic                 reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]    write_reg_q, write_reg_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;
  logic [2**ADDR_W-1:0] busy_q, busy_d;

  wb_rr_arbiter #(.RR_EN(RR_EN)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_grant (alu_grant),
    .mem_grant (mem_grant)
  );

  always_comb begin
    alu_ready   = alu_grant;
    mem_ready   = mem_grant;
    xfer        = alu_grant || mem_grant;
    xfer_rd     = mem_grant ? mem_rd   : alu_rd;
    xfer_data   = mem_grant ? mem_data : alu_data;
    issue_ready = !((issue_rd != '0) && busy_q[issue_rd]);
    rs1_busy    = (chk_rs1 != '0) && busy_q[chk_rs1];
    rs2_busy    = (chk_rs2 != '0) && busy_q[chk_rs2];

    // x0 writebacks are accepted but never reach the register file.
    reg_write_d  = xfer && (xfer_rd != '0);
    write_reg_d  = xfer ? xfer_rd   : write_reg_q;
    write_data_d = xfer ? xfer_data : write_data_q;

    // Clear applied before set so a coincident set on the same index wins.
    busy_d = busy_q;
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_vec   = busy_q;

endmodule
